// File: rtl/nms_stream.sv
// Raster-scan non-maximum suppression over a 3x3 window built from two line buffers.
// One registered output per interior pixel, 1 cycle after its accept; single output register, o_ready = !o_valid || i_ready.
module nms_stream #(
  parameter int NBIT_MAG     = 12,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int THRESH_EN    = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sof,
  input  logic [NBIT_MAG-1:0] i_mag,
  input  logic [1:0]          i_dir,
  input  logic [NBIT_MAG-1:0] i_thresh_low,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [NBIT_MAG-1:0] o_mag,
  output logic                o_eol,
  output logic                o_eof
);

  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);

  typedef logic [NBIT_MAG-1:0] mag_t;

  typedef struct packed {
    logic [1:0] dir;
    mag_t       mag;
  } pix_t;

  // One window column: top/middle/bottom magnitudes plus the middle-row direction.
  typedef struct packed {
    mag_t       t;
    mag_t       m;
    logic [1:0] dir;
    mag_t       b;
  } wcol_t;

  logic [CW-1:0] col, eff_col;
  logic [RW-1:0] row, eff_row;

  // lb0 holds row-1 with direction; lb1 holds row-2, only its magnitude is ever used.
  pix_t lb0 [IMAGE_WIDTH];
  mag_t lb1 [IMAGE_WIDTH];

  wcol_t win_l, win_c, win_r;
  pix_t  lb0_rd;
  mag_t  lb1_rd;
  mag_t  n_a, n_b, kept, nms_mag;
  logic  accept, produce, last_col, last_row;

  assign o_ready  = !o_valid || i_ready;
  assign accept   = i_valid && o_ready;

  // A start-of-frame pixel is (0,0) regardless of where the counters were.
  assign eff_col  = i_sof ? '0 : col;
  assign eff_row  = i_sof ? '0 : row;
  assign last_col = (eff_col == CW'(IMAGE_WIDTH - 1));
  assign last_row = (eff_row == RW'(IMAGE_HEIGHT - 1));
  assign produce  = (eff_row >= RW'(2)) && (eff_col >= CW'(2));

  assign lb0_rd = lb0[eff_col];
  assign lb1_rd = lb1[eff_col];

  always_comb begin
    win_r     = '0;
    win_r.t   = lb1_rd;
    win_r.m   = lb0_rd.mag;
    win_r.dir = lb0_rd.dir;
    win_r.b   = i_mag;
  end

  always_comb begin
    n_a = '0;
    n_b = '0;
    case (win_c.dir)
      2'd0: begin n_a = win_l.m; n_b = win_r.m; end
      2'd1: begin n_a = win_r.t; n_b = win_l.b; end
      2'd2: begin n_a = win_c.t; n_b = win_c.b; end
      default: begin n_a = win_l.t; n_b = win_r.b; end
    endcase
    kept    = (win_c.m >= n_a && win_c.m >= n_b) ? win_c.m : '0;
    nms_mag = kept;
    if (THRESH_EN != 0 && kept < i_thresh_low) nms_mag = '0;
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb1[eff_col] <= lb0_rd.mag;
      lb0[eff_col] <= '{dir: i_dir, mag: i_mag};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col     <= '0;
      row     <= '0;
      win_l   <= '0;
      win_c   <= '0;
      o_valid <= 1'b0;
      o_mag   <= '0;
      o_eol   <= 1'b0;
      o_eof   <= 1'b0;
    end else begin
      if (accept) begin
        win_l <= win_c;
        win_c <= win_r;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : eff_row + RW'(1);
        end else begin
          col <= eff_col + CW'(1);
          row <= eff_row;
        end
      end
      if (accept && produce) begin
        o_valid <= 1'b1;
        o_mag   <= nms_mag;
        o_eol   <= last_col;
        o_eof   <= last_col && last_row;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nms_stream.sv
// Randomized bench for nms_stream on a 5x5 frame against a window-level NMS reference model.
module tb_nms_stream;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int NB = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, o_ready, i_sof;
  logic [NB-1:0] i_mag;
  logic [1:0]    i_dir;
  logic [NB-1:0] i_thresh_low;
  logic          o_valid, i_ready;
  logic [NB-1:0] o_mag;
  logic          o_eol, o_eof;

  int checks   = 0;
  int failures = 0;

  logic [NB-1:0] fm [H][W];
  logic [1:0]    fd [H][W];

  always #5 clk = ~clk;

  nms_stream #(
    .NBIT_MAG(NB), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .THRESH_EN(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sof(i_sof), .i_mag(i_mag), .i_dir(i_dir), .i_thresh_low(i_thresh_low),
    .o_valid(o_valid), .i_ready(i_ready), .o_mag(o_mag), .o_eol(o_eol), .o_eof(o_eof)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: suppressed value for centre (y,x), packed as {eof, eol, mag}.
  function automatic logic [NB+1:0] model(input int y, input int x, input logic [NB-1:0] thr);
    logic [NB-1:0] a, b, k;
    logic          eol, eof;
    case (fd[y][x])
      2'd0: begin a = fm[y][x-1];   b = fm[y][x+1];   end
      2'd1: begin a = fm[y-1][x+1]; b = fm[y+1][x-1]; end
      2'd2: begin a = fm[y-1][x];   b = fm[y+1][x];   end
      default: begin a = fm[y-1][x-1]; b = fm[y+1][x+1]; end
    endcase
    k = (fm[y][x] >= a && fm[y][x] >= b) ? fm[y][x] : '0;
    if (k < thr) k = '0;
    eol = ((x - 1) == W - 3);
    eof = eol && ((y - 1) == H - 3);
    return {eof, eol, k};
  endfunction

  function automatic bit makes_output(input int p);
    return (p / W >= 2) && (p % W >= 2);
  endfunction

  task automatic fill(input logic [NB-1:0] m, input logic [1:0] d);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        fm[r][c] = m;
        fd[r][c] = d;
      end
  endtask

  // Feeds the first npix raster pixels of fm/fd and checks every output and every cycle's o_valid.
  task automatic run_frame(input int npix, input bit use_sof, input int stall_pct,
                           input int gap_pct, input logic [NB-1:0] thr);
    logic [NB+1:0] expq[$];
    logic [NB+1:0] gotq[$];
    logic [NB+1:0] held;
    int   p, cyc;
    bit   stall, acc, exp_v;
    for (int q = 0; q < npix; q++)
      if (makes_output(q)) expq.push_back(model(q / W - 1, q % W - 1, thr));
    p = 0;
    cyc = 0;
    i_thresh_low = thr;
    @(posedge clk); #1;
    while ((p < npix || gotq.size() < expq.size()) && cyc < 4000) begin
      i_valid = (p < npix) && ($urandom_range(0, 99) >= gap_pct);
      i_sof   = use_sof && (p == 0);
      i_mag   = (p < npix) ? fm[p / W][p % W] : '0;
      i_dir   = (p < npix) ? fd[p / W][p % W] : 2'd0;
      i_ready = ($urandom_range(0, 99) >= stall_pct);
      @(negedge clk);
      stall = o_valid && !i_ready;
      acc   = i_valid && o_ready;
      if (o_valid && i_ready) gotq.push_back({o_eof, o_eol, o_mag});
      held  = {o_eof, o_eol, o_mag};
      exp_v = stall ? 1'b1 : (acc && makes_output(p));
      if (acc) p++;
      @(posedge clk); #1;
      check("o_valid", o_valid, exp_v);
      if (stall) check("stall_hold", {o_eof, o_eol, o_mag}, held);
      cyc++;
    end
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_ready = 1'b1;
    check("fed", p, npix);
    check("count", gotq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i < gotq.size()) check($sformatf("out%0d", i), gotq[i], expq[i]);
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid = 1'b1;
    i_sof = 1'b1;
    i_mag = 12'd77;
    i_dir = 2'd0;
    i_thresh_low = '0;
    i_ready = 1'b1;

    // Reset held with traffic offered
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_mag", o_mag, '0);
    check("rst_eol", o_eol, 1'b0);
    check("rst_eof", o_eof, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    #1;
    check("rst_ready", o_ready, 1'b1);
    i_ready = 1'b1;

    // Flat frame: nine outputs of 10, eol on 3/6/9, eof on 9
    fill(12'd10, 2'd0);
    run_frame(W * H, 1'b1, 0, 0, '0);

    // Single peak, then a larger right neighbour
    fill(12'd50, 2'd0);
    fm[2][2] = 12'd100;
    run_frame(W * H, 1'b1, 0, 0, '0);
    fm[2][3] = 12'd120;
    run_frame(W * H, 1'b1, 0, 0, '0);

    // Direction sectors with a 90 neighbour around an 80 centre
    fill('0, 2'd2); fm[2][2] = 12'd80; fm[1][2] = 12'd90;
    run_frame(W * H, 1'b1, 0, 0, '0);
    fill('0, 2'd0); fm[2][2] = 12'd80; fm[1][2] = 12'd90;
    run_frame(W * H, 1'b1, 0, 0, '0);
    fill('0, 2'd1); fm[2][2] = 12'd80; fm[1][3] = 12'd90;
    run_frame(W * H, 1'b1, 0, 0, '0);
    fill('0, 2'd3); fm[2][2] = 12'd80; fm[1][1] = 12'd90;
    run_frame(W * H, 1'b1, 0, 0, '0);

    // Low threshold on isolated peaks
    fill('0, 2'd0); fm[2][2] = 12'd15;
    run_frame(W * H, 1'b1, 0, 0, 12'd20);
    fm[2][2] = 12'd25;
    run_frame(W * H, 1'b1, 0, 0, 12'd20);

    // Random frames under backpressure and input gaps
    for (int f = 0; f < 8; f++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          fm[r][c] = ($urandom_range(0, 3) == 0) ? NB'($urandom_range(0, 4095))
                                                 : NB'($urandom_range(0, 15));
          fd[r][c] = 2'($urandom_range(0, 3));
        end
      run_frame(W * H, 1'b1, (f == 0) ? 0 : 30, (f < 2) ? 0 : 20, NB'($urandom_range(0, 12)));
    end

    // Mid-frame reset with a stalled output, then resync via i_sof
    fill(12'd10, 2'd0);
    run_frame(2 * W + 2, 1'b1, 0, 0, '0);
    i_valid = 1'b1;
    i_mag   = fm[2][2];
    i_dir   = fd[2][2];
    i_ready = 1'b0;
    @(posedge clk); #1;
    check("stall_vld", o_valid, 1'b1);
    i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_vld", o_valid, 1'b0);
    check("async_mag", o_mag, '0);
    @(negedge clk);
    rst_n = 1'b1;
    i_ready = 1'b1;
    run_frame(7, 1'b0, 0, 0, '0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        fm[r][c] = NB'($urandom_range(0, 31));
        fd[r][c] = 2'($urandom_range(0, 3));
      end
    run_frame(W * H, 1'b1, 20, 10, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
